divider: RTL and testbench

Iterative 64-bit radix-2 restoring divider serving the execute stage as the inverse of the shift-add multiplier: one quotient bit per cycle, signed and unsigned, RISC-V result semantics for divide-by-zero and signed overflow. Holds the pipeline through `stallreq` until the result is ready. Drives quotient and remainder to the DIV/DIVU/REM/REMU writeback mux.

---
 rtl/divider.sv | 78 +++++++
 tb/tb_divider.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/divider.sv
// divider: iterative 64-bit radix-2 restoring divider, signed/unsigned, one quotient bit per cycle
module divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        is_signed,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        stallreq,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      r_state;
  logic [6:0]  r_cnt;
  logic [63:0] r_rem, r_q, r_b;
  logic        r_qneg, r_rneg;
  logic [63:0] w_abs_a, w_abs_b, w_diff, w_r_nxt, w_q_nxt;
  logic [64:0] w_sh;
  logic        w_ge;
  assign w_abs_a  = (is_signed & a[63]) ? -a : a;
  assign w_abs_b  = (is_signed & b[63]) ? -b : b;
  // partial remainder stays below |b|, so 64 bits hold it; the shifted value needs one more
  assign w_sh     = {r_rem, r_q[63]};
  assign w_ge     = w_sh >= {1'b0, r_b};
  assign w_diff   = w_sh[63:0] - r_b;
  assign w_r_nxt  = w_ge ? w_diff : w_sh[63:0];
  assign w_q_nxt  = {r_q[62:0], w_ge};
  assign stallreq = (r_state == IDLE && in_valid && !flush) || r_state == CALC;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: if (in_valid) begin
            r_qneg <= is_signed & (a[63] ^ b[63]);
            r_rneg <= is_signed & a[63];
            r_b    <= w_abs_b;
            r_rem  <= '0;
            r_q    <= w_abs_a;
            if (b == '0) begin
              quotient  <= '1;
              remainder <= a;
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_cnt   <= 7'd64;
              r_state <= CALC;
            end
          end
          CALC: begin
            r_rem <= w_r_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt - 7'd1;
            if (r_cnt == 7'd1) begin
              quotient  <= r_qneg ? -w_q_nxt : w_q_nxt;
              remainder <= r_rneg ? -w_r_nxt : w_r_nxt;
              out_valid <= 1'b1;
              r_state   <= DONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for the iterative divider (results, latency, stall, flush, reset)
module tb_divider;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, is_signed = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        stallreq, out_valid;
  logic [63:0] quotient, remainder;
  logic [127:0] sb[$];
  int          total = 0, bad = 0;
  longint      gcyc = 0, last_ov = 0, prev_ov;
  logic [63:0] last_q = '0, last_r = '0;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush), .is_signed(is_signed),
    .a(a), .b(b), .stallreq(stallreq), .out_valid(out_valid),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic s, input logic [63:0] x, input logic [63:0] y);
    if (y == '0) return {ONES, x};
    if (s && x == MIN && y == ONES) return {MIN, 64'h0};
    if (s) return {$signed(x) / $signed(y), $signed(x) % $signed(y)};
    return {x / y, x % y};
  endfunction

  task automatic drive(input logic s, input logic [63:0] x, input logic [63:0] y);
    @(posedge clk); #1;
    in_valid = 1'b1; is_signed = s; a = x; b = y;
  endtask

  task automatic run_op(input logic s, input logic [63:0] x, input logic [63:0] y, input int lat);
    logic [127:0] e;
    int stall_bad = 0;
    bit seen = 0;
    sb.push_back(model(s, x, y));
    drive(s, x, y);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("latency", 64'(c), 64'(lat));
        chk("stall_done", 64'(stallreq), 64'h0);
        if (sb.size() == 0) chk("sb_empty", 64'h1, 64'h0);
        else begin
          e = sb.pop_front();
          last_q = e[127:64]; last_r = e[63:0];
          chk("quotient", quotient, last_q);
          chk("remainder", remainder, last_r);
        end
        last_ov = gcyc;
        seen = 1;
        break;
      end
      if (!stallreq) stall_bad++;
    end
    if (!seen) chk("timeout", 64'h0, 64'h1);
    chk("stall_busy", 64'(stall_bad), 64'h0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ov_single", 64'(out_valid), 64'h0);
  endtask

  task automatic quiet(input int n, input string tag);
    int ov = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk(tag, 64'(ov), 64'h0);
  endtask

  initial begin
    logic s;
    logic [63:0] x, y;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", quotient, 64'h0);
    chk("rst_r", remainder, 64'h0);
    chk("rst_ov", 64'(out_valid), 64'h0);
    chk("rst_stall", 64'(stallreq), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op(0, 64'd100, 64'd7, 65);
    idle();
    run_op(1, -64'sd7, 64'd2, 65);
    run_op(0, ONES, 64'd2, 65);
    idle();
    run_op(0, 64'd5, 64'd0, 1);
    run_op(1, 64'd5, 64'd0, 1);
    run_op(1, -64'sd5, 64'd0, 1);
    idle();
    run_op(1, MIN, ONES, 65);
    idle();
    for (int i = 0; i < 5; i++) begin
      s = 1'($urandom_range(0, 1));
      x = {$urandom, $urandom};
      y = (i == 4) ? 64'h0 : ({$urandom, $urandom} >> $urandom_range(0, 60));
      run_op(s, x, y, (y == '0) ? 1 : 65);
      idle();
    end

    drive(0, 64'd1000, 64'd3);
    repeat (30) @(negedge clk);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_ov", 64'(out_valid), 64'h0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_stall", 64'(stallreq), 64'h0);
    chk("flush_q_keep", quotient, last_q);
    chk("flush_r_keep", remainder, last_r);
    run_op(0, 64'd9, 64'd3, 65);
    prev_ov = last_ov;
    run_op(1, -64'sd100, 64'd9, 65);
    chk("b2b_gap", 64'(last_ov - prev_ov), 64'd66);
    idle();

    @(posedge clk); #1 in_valid = 1'b1; flush = 1'b1; a = 64'd50; b = 64'd5;
    @(negedge clk);
    chk("flush_idle_stall", 64'(stallreq), 64'h0);
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_nostart", 64'(stallreq), 64'h0);
    quiet(70, "flush_idle_ov");

    drive(1, -64'sd1000, 64'd7);
    repeat (20) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_q", quotient, 64'h0);
    chk("midrst_r", remainder, 64'h0);
    chk("midrst_ov", 64'(out_valid), 64'h0);
    chk("midrst_stall", 64'(stallreq), 64'h0);
    quiet(70, "midrst_quiet");
    chk("sb_left", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
